minibus_decoder: RTL and testbench

Parametrised single-master, multi-slave router for the minibus request/response protocol (`minibus_req_pack` / `minibus_res_pack` from `minibus_pkg`). It sits between one bus master (core fetch/LSU port) and `NUM_SLAVES` memory-mapped slaves. It decodes each request against a parameter address map and forwards it to exactly one slave. It also generates bus errors for unmapped, misaligned or illegal requests, enforces a per-transaction timeout, and keeps a saturating error count.

---
 rtl/minibus_decoder.sv | 111 +++++++++++
 tb/tb_minibus_decoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/minibus_decoder.sv
// minibus_decoder: routes one minibus master to NUM_SLAVES address-mapped slaves with decode errors, timeout and error count
package minibus_pkg;
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  width;
      logic        ren;
      logic        wen;
   } minibus_req_pack;
   typedef struct packed {
      logic [31:0] rdata;
      logic        ack;
      logic        err;
   } minibus_res_pack;
   typedef struct packed {
      logic [31:0] addr_start;
      logic [31:0] addr_end;
   } slave_mem_map;
endpackage

module minibus_decoder
   import minibus_pkg::*;
#(
   parameter int NUM_SLAVES = 4,
   parameter slave_mem_map [NUM_SLAVES-1:0] SLAVE_MAP = '0,
   parameter int TIMEOUT_CYCLES = 256,
   parameter int ERRCNT_WIDTH = 16
) (
   input  logic                    CLK,
   input  logic                    nRST,
   input  minibus_req_pack         m_req,
   output minibus_res_pack         m_res,
   output minibus_req_pack         s_req [NUM_SLAVES],
   input  minibus_res_pack         s_res [NUM_SLAVES],
   output logic                    busy,
   output logic [ERRCNT_WIDTH-1:0] err_count
);
   localparam int SW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
   typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;
   state_t          state;
   logic [SW-1:0]   sel;
   logic [SW-1:0]   hit_idx;
   logic [31:0]     tcnt;
   logic            hit;
   logic            valid;
   logic            bad;
   logic            resp;
   logic            tout;
   minibus_res_pack rsp;
   assign valid = m_req.ren | m_req.wen;
   assign rsp   = s_res[sel];
   assign resp  = rsp.ack | rsp.err;
   assign tout  = (TIMEOUT_CYCLES != 0) && (tcnt == 32'(TIMEOUT_CYCLES - 1));
   assign bad   = (m_req.ren & m_req.wen) | (m_req.width == 2'd3) | !hit |
                  (m_req.width == 2'd1 & m_req.addr[0]) |
                  (m_req.width == 2'd2 & |m_req.addr[1:0]);
   // scan downward so the lowest matching index wins on overlap
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--)
         if (m_req.addr >= SLAVE_MAP[i].addr_start && m_req.addr < SLAVE_MAP[i].addr_end) begin
            hit     = 1'b1;
            hit_idx = SW'(i);
         end
   end
   always_comb
      for (int i = 0; i < NUM_SLAVES; i++)
         s_req[i] = (state == BUSY && sel == SW'(i)) ? m_req : '0;
   always_comb begin
      m_res = '0;
      if (state == ERR)
         m_res.err = 1'b1;
      else if (state == BUSY && valid) begin
         m_res     = rsp;
         m_res.ack = rsp.ack & ~rsp.err;
         if (tout && !resp)
            m_res = '{rdata: '0, ack: 1'b0, err: 1'b1};
      end
   end
   always_ff @(posedge CLK)
      if (!nRST) begin
         state     <= IDLE;
         sel       <= '0;
         tcnt      <= '0;
         busy      <= 1'b0;
         err_count <= '0;
      end else begin
         if (m_res.err && !(&err_count))
            err_count <= err_count + 1'b1;
         case (state)
            IDLE:
               if (valid) begin
                  state <= bad ? ERR : BUSY;
                  busy  <= 1'b1;
                  sel   <= bad ? sel : hit_idx;
                  tcnt  <= '0;
               end
            BUSY:
               if (!valid || resp || tout) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else
                  tcnt <= tcnt + 32'd1;
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
endmodule

// File: tb/tb_minibus_decoder.sv
// tb_minibus_decoder: directed vector table plus timeout, reset and saturation sequences
module tb_minibus_decoder;
   import minibus_pkg::*;
   localparam slave_mem_map [1:0] MAP = {
      slave_mem_map'{32'h1000_0000, 32'h1000_0100},
      slave_mem_map'{32'h0000_0000, 32'h0000_1000}};
   typedef struct {
      minibus_req_pack req;
      int              rs;
      int              wt;
      minibus_res_pack sres;
      int              exp_lat;
      minibus_res_pack exp_res;
   } vec_t;
   logic            clk = 1'b0;
   logic            nrst = 1'b0;
   minibus_req_pack m_req = '0;
   minibus_res_pack m_res;
   minibus_req_pack s_req [2];
   minibus_res_pack s_res [2];
   logic            busy;
   logic [3:0]      err_count;
   int              n_chk = 0;
   int              n_fail = 0;
   logic [3:0]      cnt_model = '0;
   vec_t            tv [14];
   minibus_decoder #(
      .NUM_SLAVES(2), .SLAVE_MAP(MAP), .TIMEOUT_CYCLES(8), .ERRCNT_WIDTH(4)
   ) dut (
      .CLK(clk), .nRST(nrst), .m_req(m_req), .m_res(m_res),
      .s_req(s_req), .s_res(s_res), .busy(busy), .err_count(err_count)
   );
   always #5 clk = ~clk;
   function automatic minibus_req_pack mk_req(input logic [31:0] a, input logic [31:0] d,
                                              input logic [1:0] w, input logic r, input logic wr);
      return '{addr: a, wdata: d, width: w, ren: r, wen: wr};
   endfunction
   function automatic minibus_res_pack mk_res(input logic [31:0] d, input logic a, input logic e);
      return '{rdata: d, ack: a, err: e};
   endfunction
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic clr_res();
      s_res[0] = '0;
      s_res[1] = '0;
   endtask
   task automatic bump();
      cnt_model = (cnt_model == 4'hF) ? 4'hF : cnt_model + 4'd1;
   endtask
   task automatic run(input vec_t v, input string tag);
      int lat = -1;
      int leak = 0;
      int idle_busy = 0;
      minibus_res_pack got = '0;
      @(posedge clk); #1;
      m_req = v.req;
      clr_res();
      for (int c = 0; c <= 12 && lat < 0; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         clr_res();
         if (v.rs >= 0 && c == v.wt + 1)
            s_res[v.rs] = v.sres;
         @(negedge clk);
         if (c == 1 && v.rs >= 0)
            chk({tag, " route"}, s_req[v.rs], v.req);
         for (int j = 0; j < 2; j++)
            if (j != v.rs && s_req[j] != '0)
               leak++;
         if (c >= 1 && !busy)
            idle_busy++;
         if (m_res.ack || m_res.err) begin
            lat = c;
            got = m_res;
         end
      end
      if (v.exp_res.err)
         bump();
      @(posedge clk); #1;
      m_req = '0;
      clr_res();
      @(negedge clk);
      chk({tag, " latency"}, lat, v.exp_lat);
      chk({tag, " m_res"}, got, v.exp_res);
      chk({tag, " leakage"}, leak, 0);
      chk({tag, " busy_during"}, idle_busy, 0);
      chk({tag, " busy_after"}, busy, 1'b0);
      chk({tag, " m_res_idle"}, m_res, '0);
      chk({tag, " err_count"}, err_count, cnt_model);
   endtask
   initial begin
      int first_err;
      minibus_req_pack r;
      vec_t unm;
      tv[0]  = '{mk_req(32'h1000_0004, 0, 2, 1, 0), 1, 0, mk_res(32'hDEADBEEF, 1, 0), 1, mk_res(32'hDEADBEEF, 1, 0)};
      tv[1]  = '{mk_req(32'h0000_0FFC, 32'h12345678, 2, 0, 1), 0, 3, mk_res(0, 1, 0), 4, mk_res(0, 1, 0)};
      tv[2]  = '{mk_req(32'h2000_0000, 0, 2, 1, 0), -1, 0, '0, 1, mk_res(0, 0, 1)};
      tv[3]  = '{mk_req(32'h0000_0002, 0, 2, 1, 0), -1, 0, '0, 1, mk_res(0, 0, 1)};
      tv[4]  = '{mk_req(32'h0000_0000, 0, 3, 1, 0), -1, 0, '0, 1, mk_res(0, 0, 1)};
      tv[5]  = '{mk_req(32'h1000_0001, 0, 1, 1, 0), -1, 0, '0, 1, mk_res(0, 0, 1)};
      tv[6]  = '{mk_req(32'h0000_0010, 0, 2, 1, 1), -1, 0, '0, 1, mk_res(0, 0, 1)};
      tv[7]  = '{mk_req(32'h0000_0003, 0, 0, 1, 0), 0, 1, mk_res(0, 0, 1), 2, mk_res(0, 0, 1)};
      tv[8]  = '{mk_req(32'h1000_0020, 0, 2, 1, 0), 1, 0, mk_res(0, 1, 1), 1, mk_res(0, 0, 1)};
      tv[9]  = '{mk_req(32'h1000_00FE, 0, 1, 1, 0), 1, 2, mk_res(32'h0000BEEF, 1, 0), 3, mk_res(32'h0000BEEF, 1, 0)};
      tv[10] = '{mk_req(32'h1000_0100, 0, 2, 1, 0), -1, 0, '0, 1, mk_res(0, 0, 1)};
      tv[11] = '{mk_req(32'h0FFF_FFFC, 0, 2, 1, 0), -1, 0, '0, 1, mk_res(0, 0, 1)};
      tv[12] = '{mk_req(32'h0000_0000, 32'hA5, 0, 0, 1), 0, 0, mk_res(0, 1, 0), 1, mk_res(0, 1, 0)};
      tv[13] = '{mk_req(32'h0000_0FFE, 0, 1, 1, 0), 0, 0, mk_res(32'h00001234, 1, 0), 1, mk_res(32'h00001234, 1, 0)};
      clr_res();
      repeat (3) @(posedge clk);
      #1 nrst = 1'b1;
      @(negedge clk);
      chk("reset m_res", m_res, '0);
      chk("reset s_req0", s_req[0], '0);
      chk("reset s_req1", s_req[1], '0);
      chk("reset busy", busy, 1'b0);
      chk("reset err_count", err_count, 4'd0);
      for (int i = 0; i < 14; i++) begin
         run(tv[i], $sformatf("vec%0d", i));
         if (i == 4)
            chk("three decode errors", err_count, 4'd3);
      end
      // timeout: slave1 never answers
      r = mk_req(32'h1000_0008, 0, 2, 1, 0);
      first_err = -1;
      @(posedge clk); #1;
      m_req = r;
      for (int c = 0; c <= 12; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         if (c == 9)
            m_req = '0;
         clr_res();
         if (c == 12)
            s_res[1] = mk_res(32'hCAFE, 1, 0);
         @(negedge clk);
         if (first_err < 0 && m_res.err)
            first_err = c;
         if (c == 8)
            chk("timeout m_res", m_res, mk_res(0, 0, 1));
         if (c == 9)
            chk("timeout s_req dropped", s_req[1], '0);
         if (c == 12)
            chk("late ack ignored", m_res, '0);
      end
      bump();
      chk("timeout latency", first_err, 8);
      @(posedge clk); #1;
      clr_res();
      @(negedge clk);
      chk("timeout err_count", err_count, cnt_model);
      // reset in the middle of a slave0 transaction
      r = mk_req(32'h0000_0010, 0, 2, 1, 0);
      @(posedge clk); #1;
      m_req = r;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("pre-reset busy", busy, 1'b1);
      chk("pre-reset s_req0", s_req[0], r);
      @(posedge clk); #1;
      nrst = 1'b0;
      @(posedge clk); #1;
      nrst = 1'b1;
      m_req = '0;
      cnt_model = '0;
      @(negedge clk);
      chk("mid reset busy", busy, 1'b0);
      chk("mid reset m_res", m_res, '0);
      chk("mid reset s_req0", s_req[0], '0);
      chk("mid reset s_req1", s_req[1], '0);
      chk("mid reset err_count", err_count, 4'd0);
      run(tv[0], "post-reset read");
      unm = tv[2];
      for (int i = 0; i < 17; i++)
         run(unm, $sformatf("sat%0d", i));
      chk("err_count saturated", err_count, 4'hF);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
